// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding and
// fixed constants used by the stage and its bench.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/imem_bytes.sv
// Byte-wide instruction memory: synchronous byte write port and a combinational
// big-endian 32-bit read of the word containing rd_addr.
module imem_bytes #(
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic                         CLK,
  input  logic                         wr_en,
  input  logic [$clog2(MEM_BYTES)-1:0] wr_addr,
  input  logic [7:0]                   wr_data,
  input  logic [$clog2(MEM_BYTES)-1:0] rd_addr,
  output logic [31:0]                  rd_data
);

  localparam int unsigned AW = $clog2(MEM_BYTES);

  // Contents start at zero and are never touched by reset.
  logic [7:0]    mem [MEM_BYTES] = '{default: '0};
  logic [AW-1:0] base;

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    base    = rd_addr & ~AW'(3);
    rd_data = {mem[base], mem[base | AW'(1)], mem[base | AW'(2)], mem[base | AW'(3)]};
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetch FSM and the registered output
// slot handed to decode over a valid/ready handshake.
module if_fetch_stage #(
  parameter int unsigned MEM_BYTES = 64,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        en,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        fault,
  output logic [31:0] fault_pc
);

  import if_pkg::*;

  localparam int unsigned AW        = $clog2(MEM_BYTES);
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  mem_word;
  logic         slot_free;
  logic         consumed;
  logic         pc_bad;
  logic         unused_wr_hi;

  assign unused_wr_hi = ^wr_addr[31:AW];

  imem_bytes #(.MEM_BYTES(MEM_BYTES)) u_imem (
    .CLK     (CLK),
    .wr_en   (wr_en),
    .wr_addr (wr_addr[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (pc[AW-1:0]),
    .rd_data (mem_word)
  );

  always_comb begin
    slot_free = !if_valid || id_ready;
    consumed  = if_valid && id_ready;
    pc_bad    = (pc[1:0] != 2'b00) || (pc > LAST_WORD);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= NOP_INSTR;
      if_pc       <= RESET_PC;
      if_pc_plus4 <= RESET_PC + PC_STEP;
      fault       <= 1'b0;
      fault_pc    <= '0;
    end else if (redirect_valid) begin
      // Flush wins over acceptance; the new PC is fetched on the following cycle.
      if_valid <= 1'b0;
      pc       <= redirect_pc;
      fault    <= 1'b0;
      state    <= en ? FETCH : IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (consumed) if_valid <= 1'b0;
          if (en) state <= FETCH;
        end
        FETCH: begin
          if (!en) begin
            if (consumed) if_valid <= 1'b0;
            state <= IDLE;
          end else if (slot_free) begin
            if (pc_bad) begin
              fault    <= 1'b1;
              fault_pc <= pc;
              if_valid <= 1'b0;
              state    <= FAULT;
            end else begin
              if_instr    <= mem_word;
              if_pc       <= pc;
              if_pc_plus4 <= pc + PC_STEP;
              if_valid    <= 1'b1;
              pc          <= pc + PC_STEP;
            end
          end
        end
        FAULT: begin
          if (consumed) if_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed and randomized bench for if_fetch_stage against a cycle-level
// behavioural model of the fetch rules.
module tb_if_fetch_stage;

  localparam int unsigned MEM = 64;

  logic        CLK = 1'b0;
  logic        RESET, en, id_ready, redirect_valid, wr_en;
  logic [31:0] redirect_pc, wr_addr;
  logic [7:0]  wr_data;
  logic        if_valid, fault;
  logic [31:0] if_instr, if_pc, if_pc_plus4, fault_pc;

  int checks = 0;
  int errors = 0;

  byte unsigned m_mem [MEM];
  logic [31:0]  m_pc, m_instr, m_ipc, m_fpc;
  bit           m_valid, m_fault, m_active;

  if_fetch_stage #(.MEM_BYTES(MEM), .RESET_PC(32'h0)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .en             (en),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    int unsigned b = int'(a % MEM);
    return {m_mem[b], m_mem[b + 1], m_mem[b + 2], m_mem[b + 3]};
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_valid = 0; m_instr = 32'h0; m_ipc = 32'h0;
    m_fault = 0; m_fpc = 32'h0; m_active = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_next();
    bit take = m_valid && id_ready;
    if (redirect_valid) begin
      m_valid = 0; m_pc = redirect_pc; m_fault = 0; m_active = en;
    end else if (m_fault) begin
      if (take) m_valid = 0;
    end else if (!m_active || !en) begin
      if (take) m_valid = 0;
      m_active = en;
    end else if (!m_valid || id_ready) begin
      if ((m_pc % 4) != 0 || m_pc > MEM - 4) begin
        m_fault = 1; m_fpc = m_pc; m_valid = 0;
      end else begin
        m_instr = word_at(m_pc); m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 32'd4;
      end
    end
    if (wr_en) m_mem[wr_addr % MEM] = wr_data;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".valid"}, {31'b0, if_valid}, {31'b0, m_valid});
    chk({tag, ".instr"}, if_instr, m_instr);
    chk({tag, ".pc"}, if_pc, m_ipc);
    chk({tag, ".pc4"}, if_pc_plus4, m_ipc + 32'd4);
    chk({tag, ".fault"}, {31'b0, fault}, {31'b0, m_fault});
    chk({tag, ".fault_pc"}, fault_pc, m_fpc);
  endtask

  task automatic step(input string tag);
    model_next();
    @(posedge CLK);
    #1;
    compare_all(tag);
  endtask

  // Called 1 time unit after a posedge: reset pulse entirely between edges.
  task automatic pulse_reset();
    #2 RESET = 1'b1;
    #1;
    model_reset();
    compare_all("async_rst");
    #2 RESET = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] a, input string tag);
    redirect_valid = 1'b1; redirect_pc = a;
    step(tag);
    redirect_valid = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; en = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < MEM; i++) m_mem[i] = 8'h00;
    model_reset();
    #3;
    compare_all("reset");
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 32'(i); wr_data = 8'(i);
      step("load");
    end
    wr_en = 1'b0;
    pulse_reset();

    en = 1'b1; id_ready = 1'b1;
    step("start");
    chk("start.idle_valid", {31'b0, if_valid}, 32'd0);
    step("seq0"); chk("seq0.word", if_instr, 32'h0001_0203);
    step("seq1"); chk("seq1.word", if_instr, 32'h0405_0607); chk("seq1.addr", if_pc, 32'h4);
    step("seq2"); chk("seq2.word", if_instr, 32'h0809_0A0B); chk("seq2.pc4", if_pc_plus4, 32'hC);

    redirect_to(32'h0, "st_rd");
    step("st_f0"); chk("st_f0.word", if_instr, 32'h0001_0203);
    id_ready = 1'b0;
    repeat (3) step("stall");
    chk("stall.word", if_instr, 32'h0001_0203);
    chk("stall.pc4", if_pc_plus4, 32'h4);
    id_ready = 1'b1;
    step("release"); chk("release.word", if_instr, 32'h0405_0607);

    redirect_to(32'h8, "redir");
    chk("redir.flush", {31'b0, if_valid}, 32'd0);
    step("redir_f"); chk("redir_f.word", if_instr, 32'h0809_0A0B); chk("redir_f.addr", if_pc, 32'h8);

    redirect_to(32'h6, "mis_rd");
    step("mis");
    chk("mis.fault", {31'b0, fault}, 32'd1); chk("mis.fpc", fault_pc, 32'h6);
    step("mis_hold"); chk("mis_hold.fault", {31'b0, fault}, 32'd1);
    redirect_to(32'(MEM), "oor_rd");
    chk("oor_rd.clear", {31'b0, fault}, 32'd0);
    step("oor");
    chk("oor.fault", {31'b0, fault}, 32'd1); chk("oor.fpc", fault_pc, 32'h40);

    redirect_to(32'h0, "clr");
    wr_en = 1'b1; wr_addr = 32'h0; wr_data = 8'hFF;
    step("rbw"); chk("rbw.old", if_instr, 32'h0001_0203);
    wr_en = 1'b0;
    redirect_to(32'h0, "rbw_rd");
    step("rbw_new"); chk("rbw_new.word", if_instr, 32'hFF01_0203);
    step("mid");
    pulse_reset();
    step("post_idle");
    step("post0"); chk("post0.kept", if_instr, 32'hFF01_0203);
    step("post1"); chk("post1.kept", if_instr, 32'h0405_0607);

    repeat (400) begin
      en = ($urandom_range(0, 9) != 0);
      id_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 5))
        0, 1, 2, 3: redirect_pc = 32'($urandom_range(0, 15) * 4);
        4:          redirect_pc = 32'($urandom_range(0, MEM + 8));
        default:    redirect_pc = 32'hFFFF_FFFC;
      endcase
      wr_en = ($urandom_range(0, 4) == 0);
      wr_addr = $urandom;
      wr_data = 8'($urandom);
      step("rand");
      if ($urandom_range(0, 99) == 0) pulse_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage: owns the program counter and a byte-addressed instruction memory.
- Each fetch assembles one 32-bit big-endian instruction.
- Presents the instruction with its PC to the decode stage through a valid/ready handshake.
- Supports branch/jump redirect, stall by backpressure, run enable, and an alignment/range fault.

Parameters:
- MEM_BYTES, 64, instruction memory size in bytes; power of 2, minimum 4.
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RESET  in  1  reset, asynchronous, active-high.
- en  in  1  run enable; 0 stops issuing new fetches.
- id_ready  in  1  decode accepts the current output this cycle.
- redirect_valid  in  1  branch/jump taken; flush and load redirect_pc.
- redirect_pc  in  32  new fetch address.
- wr_en  in  1  instruction memory byte write strobe (program load).
- wr_addr  in  32  byte address for the write; bits above log2(MEM_BYTES) ignored.
- wr_data  in  8  byte to write.
- if_valid  out  1  if_instr/if_pc hold a valid instruction.
- if_instr  out  32  fetched instruction.
- if_pc  out  32  address of if_instr.
- if_pc_plus4  out  32  if_pc + 4, modulo 2^32.
- fault  out  1  sticky fetch fault.
- fault_pc  out  32  PC that caused the fault.

Behaviour:
- Reset values, asynchronous: pc = RESET_PC, if_valid = 0, if_instr = 32'h0 (NOP), if_pc = RESET_PC, if_pc_plus4 = RESET_PC+4, fault = 0, fault_pc = 0, state = IDLE.
- Memory contents are not affected by RESET; they initialise to all-zero at time 0.
- Output slot is free when if_valid = 0, or when if_valid = 1 and id_ready = 1.
- States and transitions:
  - IDLE: no fetch. en = 1 -> FETCH.
  - FETCH: pc is checked combinationally. A fault occurs when pc[1:0] != 0 or pc > MEM_BYTES-4.
    - No fault and slot free: on the next posedge, if_instr = {mem[pc], mem[pc+1], mem[pc+2], mem[pc+3]}, if_pc = pc, if_valid = 1, pc <= pc+4 (wraps 32'hFFFF_FFFC -> 0).
    - Slot not free: hold all outputs and pc (stall).
    - Fault and slot free: fault <= 1, fault_pc <= pc, if_valid <= 0 -> FAULT.
    - Fault with slot not free: hold until drained, then take the fault.
    - en = 0: go to IDLE; the pending output stays until accepted.
  - FAULT: no fetch; fault stays 1. Only RESET or redirect_valid leaves FAULT.
- Latency: one cycle from PC to registered instruction. Sustained throughput is one instruction per cycle while id_ready = 1.
- Redirect, highest priority in any state except during RESET:
  - Next posedge: if_valid <= 0 (the wrong-path instruction is flushed even if id_ready = 1), pc <= redirect_pc, fault <= 0.
  - Next state is FETCH if en = 1, else IDLE.
  - The fetch from redirect_pc happens on the following cycle, giving a redirect penalty of 1 bubble.
- Simultaneous id_ready and redirect_valid: the output is considered consumed, the flush still applies, and no new fetch happens in that cycle.
- Memory writes: synchronous on posedge when wr_en = 1, and allowed in any state.
  - A fetch in the same cycle as a write to one of its bytes returns the old byte (read before write).
- Reset mid-operation: immediately clears if_valid and fault and returns to IDLE. The in-flight instruction is dropped.

Decomposition:
- Shared package if_pkg:
  - NOP_INSTR = 32'h0.
  - Fetch state encoding: IDLE = 2'd0, FETCH = 2'd1, FAULT = 2'd2.
  - PC_STEP = 4.
- Sub-module imem_bytes (parameter MEM_BYTES):
  - Byte array with a synchronous write port.
  - Combinational 4-byte big-endian read at a word-aligned address.
- The stage instantiates imem_bytes and holds the PC, FSM and output register.

Test Plan:
- Load bytes 00..0F with 0x00..0x0F, RESET pulse, en = 1, id_ready = 1.
  -> if_instr = 0x00010203 @pc 0, 0x04050607 @4, 0x08090A0B @8 on consecutive cycles; if_pc_plus4 = if_pc+4.
- Stall: hold id_ready = 0 for 3 cycles after the first valid.
  -> if_instr stays 0x00010203 and pc stays 4; on release, 0x04050607 follows on the next cycle.
- Redirect: redirect_valid = 1, redirect_pc = 0x8 while if_pc = 0x4.
  -> next cycle if_valid = 0; the cycle after, if_instr = 0x08090A0B, if_pc = 8.
- Fault: redirect to 0x6 (misaligned), then separately to MEM_BYTES.
  -> fault = 1, fault_pc = 0x6 (resp. 0x40), if_valid = 0; state is FAULT until redirect_pc = 0 clears it.
- Async RESET asserted mid-stream between clock edges.
  -> if_valid = 0 and if_pc = RESET_PC immediately; memory contents preserved.
- Same-cycle write and fetch of byte 0 with wr_data = 0xFF.
  -> fetched word = 0x00010203; the next fetch of 0 after redirect returns 0xFF010203.
